// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, instruction field positions and buffer entry layout.
package cpu_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned OP_FIELD_HI = 31;
  localparam int unsigned OP_FIELD_LO = 26;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrop
  } ifetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } ifetch_entry_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer with push, pop and flush; flush voids any same-cycle push or pop.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  ifetch_entry_t   wdata,
  output ifetch_entry_t   rdata,
  output logic [CntW-1:0] count
);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  ifetch_entry_t   mem_q [FIFO_DEPTH];
  ifetch_entry_t   mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_push  = push && !flush && (cnt_q != DepthCnt);
    do_pop   = pop && !flush && (cnt_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_ir.sv
// Instruction fetch unit: IDLE/FETCH/DROP request FSM feeding a registered instruction buffer.
// Optional IFETCH_PERF_EN adds a saturating decode-stall cycle counter output (stall_cnt).
module ifetch_ir
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             imem_req,
  output logic [31:0]                      imem_addr,
  input  logic                             imem_ack,
  input  logic [INSTR_W-1:0]               imem_rdata,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [INSTR_W-1:0]               instr,
  output logic [OP_FIELD_HI-OP_FIELD_LO:0] op_code,
  output logic [31:0]                      instr_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int unsigned     CntW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  ifetch_state_t   state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic            fifo_push, fifo_pop, fifo_flush;
  ifetch_entry_t   fifo_wdata, fifo_head;
  logic [CntW-1:0] fifo_cnt;
  logic [CntW-1:0] cnt_post;

  assign instr_valid = (fifo_cnt != '0);
  assign fifo_pop    = instr_valid && instr_ready;
  assign fifo_wdata  = {imem_rdata, pc_q};
  assign cnt_post    = fifo_cnt + CntW'(1) - CntW'(fifo_pop);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = align_pc(redirect_pc);
    end
    case (state_q)
      StIdle: begin
        if (!redirect_valid && (fifo_cnt < DepthCnt)) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          // The in-flight read still has to complete at its original address.
          drop_addr_d = pc_q;
          state_d     = imem_ack ? StIdle : StDrop;
        end else if (imem_ack) begin
          fifo_push = 1'b1;
          pc_d      = pc_incr(pc_q);
          if (cnt_post >= DepthCnt) begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  ifetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (fifo_cnt)
  );

  // Hide stale storage so an empty buffer always presents zeros.
  assign instr    = instr_valid ? fifo_head.instr : '0;
  assign instr_pc = instr_valid ? fifo_head.pc : '0;
  assign op_code  = instr[OP_FIELD_HI:OP_FIELD_LO];

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (instr_ready && !instr_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir with a queue-based reference model and a reactive memory.
module tb_ifetch_ir;

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam int          Depth   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [5:0]  op_code;
`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ifetch_ir #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .op_code        (op_code),
    .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h3C00_0001 + ((a - 32'h0000_3000) << 24);
  endfunction

  // Reference model: entries are {instr, pc}; a request is either absent, live or being discarded.
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_req_addr, m_stall;
  bit          m_busy, m_discard;
  int          lat, wcnt, ack_count;
  bit          armed;

  task automatic cycle();
    logic        ack;
    logic [31:0] rd;
    int          n0;
    bit          pop;
    ack = armed && (imem_req === 1'b1) && (wcnt == lat);
    rd  = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    imem_ack   = ack;
    imem_rdata = rd;
    #1;
    if (armed) begin
      chk("imem_req", 32'(imem_req), 32'(m_busy));
      if (m_busy) chk("imem_addr", imem_addr, m_req_addr);
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
      chk("instr", instr, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
      chk("instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0][31:0] : 32'd0);
      chk("op_code", 32'(op_code), (m_q.size() != 0) ? 32'(m_q[0][63:58]) : 32'd0);
`ifdef IFETCH_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
    if (ack) ack_count++;
    n0  = m_q.size();
    pop = (n0 != 0) && instr_ready;
    if (rst) begin
      m_q.delete();
      m_pc      = ResetPc;
      m_busy    = 1'b0;
      m_discard = 1'b0;
      m_stall   = '0;
    end else begin
      if (instr_ready && n0 == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_busy) begin
          if (ack) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
          end else begin
            m_discard = 1'b1;
          end
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_busy && ack) begin
          if (m_discard) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
          end else begin
            m_q.push_back({rd, m_req_addr});
            m_pc       = m_req_addr + 32'd4;
            m_req_addr = m_pc;
            m_busy     = (m_q.size() < Depth);
          end
        end else if (!m_busy && n0 < Depth) begin
          m_busy     = 1'b1;
          m_req_addr = m_pc;
        end
      end
    end
    wcnt = ((imem_req === 1'b1) && !ack) ? wcnt + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    armed = 1'b1;
    cycle();
    rst = 1'b0;
    ack_count = 0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (imem_req === 1'b1) seen = 1'b1;
      else cycle();
    end
    chk({name, " req seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (instr_valid === 1'b1) seen = 1'b1;
      else cycle();
    end
    chk({name, " valid seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [23:0] ready_pat;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; lat = 0; wcnt = 0; armed = 1'b0; ack_count = 0;
    m_pc = ResetPc; m_req_addr = '0; m_stall = '0; m_busy = 1'b0; m_discard = 1'b0;
    @(negedge clk);

    // Reset state and zero-wait streaming.
    instr_ready = 1'b1;
    do_reset();
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst op_code", 32'(op_code), 32'd0);
    cycle();
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'h0000_3000);
    cycle();
    chk("first valid", 32'(instr_valid), 32'd1);
    chk("first op_code", 32'(op_code), 32'h0F);
    chk("first instr_pc", instr_pc, 32'h0000_3000);
    chk("second addr", imem_addr, 32'h0000_3004);
    cycle();
    chk("third addr", imem_addr, 32'h0000_3008);
    chk("second op_code", 32'(op_code), 32'h10);
    repeat (4) cycle();

    // Decode stalled: buffer fills and fetching stops, then resumes in order.
    instr_ready = 1'b0;
    do_reset();
    repeat (3) cycle();
    chk("full req", 32'(imem_req), 32'd0);
    chk("full acks", 32'(ack_count), 32'd2);
    repeat (3) cycle();
    chk("full hold req", 32'(imem_req), 32'd0);
    chk("full hold acks", 32'(ack_count), 32'd2);
    instr_ready = 1'b1;
    wait_req("resume");
    chk("resume addr", imem_addr, 32'h0000_3008);
    repeat (3) cycle();

    // Redirect during a slow read: old read drains in DROP, data is thrown away.
    lat = 3;
    do_reset();
    cycle();
    cycle();
    redirect_to(32'h0000_4000);
    chk("drop req", 32'(imem_req), 32'd1);
    chk("drop addr", imem_addr, 32'h0000_3000);
    cycle();
    cycle();
    chk("after drop req", 32'(imem_req), 32'd0);
    chk("after drop valid", 32'(instr_valid), 32'd0);
    wait_req("redirect");
    chk("redirect addr", imem_addr, 32'h0000_4000);
    chk("redirect no stale", 32'(instr_valid), 32'd0);
    wait_valid("redirect");
    chk("redirect head pc", instr_pc, 32'h0000_4000);

    // Redirect colliding with an ack and a pop; low address bits are dropped.
    lat = 0;
    do_reset();
    cycle();
    cycle();
    chk("collide pre valid", 32'(instr_valid), 32'd1);
    redirect_to(32'h0000_5001);
    chk("collide flushed", 32'(instr_valid), 32'd0);
    wait_valid("collide");
    chk("collide head pc", instr_pc, 32'h0000_5000);
    chk("collide head instr", instr, 32'h3C00_0001);

    // Address wrap at the top of memory.
    redirect_to(32'hFFFF_FFFE);
    wait_req("wrap");
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap next addr", imem_addr, 32'h0000_0000);
    chk("wrap head pc", instr_pc, 32'hFFFF_FFFC);
    repeat (3) cycle();

    // Reset while a read is outstanding: request withdrawn without DROP.
    lat = 3;
    do_reset();
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst mid req", 32'(imem_req), 32'd0);
    chk("rst mid valid", 32'(instr_valid), 32'd0);
    wait_req("rst mid");
    chk("rst mid addr", imem_addr, ResetPc);
    repeat (6) cycle();

    // Mixed ready pattern with one-cycle memory latency.
    lat = 1;
    ready_pat = 24'b1011_0010_1110_0101_0011_1101;
    for (int i = 0; i < 24; i++) begin
      instr_ready = ready_pat[i];
      if (i == 13) redirect_to(32'h0000_6000);
      else cycle();
    end

`ifdef IFETCH_PERF_EN
    // Stall counting with a four-cycle memory latency.
    lat = 4;
    instr_ready = 1'b1;
    do_reset();
    chk("perf rst", stall_cnt, 32'd0);
    repeat (6) cycle();
    chk("perf valid", 32'(instr_valid), 32'd1);
    chk("perf count", stall_cnt, 32'd6);
    do_reset();
    chk("perf clear", stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_ir.md
IFETCH_IR -- requirements
Module: ifetch_ir

Interface
- REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries (legal values 2..4).
- REQ-003 SHALL use one clock; reset is synchronous and active-high.
- REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
- REQ-006 SHALL have port imem_req, output, 1 bit: instruction memory read request.
- REQ-007 SHALL have port imem_addr, output, 32 bits: word-aligned read address.
- REQ-008 SHALL have port imem_ack, input, 1 bit: single-cycle read completion.
- REQ-009 SHALL have port imem_rdata, input, 32 bits: read data, valid only while imem_ack=1.
- REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
- REQ-011 SHALL have port redirect_pc, input, 32 bits: new fetch address.
- REQ-012 SHALL have port instr_valid, output, 1 bit: the buffer head is valid.
- REQ-013 SHALL have port instr_ready, input, 1 bit: the decode stage accepts the head.
- REQ-014 SHALL have port instr, output, 32 bits: the head instruction word.
- REQ-015 SHALL have port op_code, output, 6 bits: instr[31:26], fed to the decoders.
- REQ-016 SHALL have port instr_pc, output, 32 bits: the address of the head instruction.

Function
- REQ-017 SHALL implement a 3-state FSM: IDLE, FETCH, DROP.
- REQ-018 IDLE -> FETCH on the next edge when (entries + 0) < FIFO_DEPTH and redirect_valid=0.
- REQ-019 In FETCH and DROP, imem_req SHALL be 1.
- REQ-020 In FETCH and DROP, imem_addr SHALL stay stable until the cycle imem_ack=1; an ack in the first FETCH cycle is legal (zero wait).
- REQ-021 In IDLE, imem_req SHALL be 0.
- REQ-022 On FETCH with imem_ack=1 and no redirect, the FSM SHALL:
  - push {imem_rdata, pc} into the buffer;
  - set pc to pc+4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0);
  - stay in FETCH if the post-push/pop count < FIFO_DEPTH, else go to IDLE.
- REQ-023 instr_valid SHALL equal buffer-not-empty.
- REQ-024 The head SHALL pop on instr_valid && instr_ready.
- REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged.
- REQ-026 Fetch latency SHALL be: ack in cycle N -> instr_valid=1 in cycle N+1 (registered buffer, no bypass).
- REQ-027 redirect_valid=1 SHALL have highest priority:
  - the buffer is flushed and pc is set to redirect_pc on the edge;
  - any same-cycle pop is void.
- REQ-028 Redirect in FETCH with imem_ack=0 SHALL go to DROP; DROP keeps the old address, discards the data on ack, then goes to IDLE.
- REQ-029 Redirect with a same-cycle imem_ack SHALL discard the data and go to IDLE.
- REQ-030 Redirect while in DROP SHALL update pc only; the FSM remains in DROP.
- REQ-031 Redirect in IDLE SHALL update pc; the next edge follows REQ-018.
- REQ-032 redirect_pc[1:0] SHALL be forced to 0.
- REQ-033 The buffer SHALL never overflow; no fetch is issued when full. An empty pop is impossible by REQ-023.

Reset
- REQ-034 rst=1 SHALL set: state=IDLE, pc=RESET_PC, buffer empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0, op_code=0.
- REQ-035 rst asserted mid-FETCH SHALL abandon the request with no DROP; the memory model must tolerate the withdrawn request.
- REQ-036 rst SHALL override redirect_valid.

Configuration
- REQ-037 Macro IFETCH_PERF_EN defined SHALL add output stall_cnt, 32 bits: counts cycles with instr_ready=1 && instr_valid=0, saturates at 32'hFFFF_FFFF, cleared by rst.
- REQ-038 Without IFETCH_PERF_EN, the port and counter SHALL be absent and function SHALL be otherwise identical.

Structure
- REQ-039 Package cpu_pkg SHALL hold:
  - the FSM state enum ifetch_state_t;
  - OP_FIELD_HI=31 and OP_FIELD_LO=26;
  - INSTR_W=32.
  The existing OP_CODE_* definitions remain in their include.
- REQ-040 The buffer SHALL be sub-module ifetch_fifo: synchronous FIFO with push, pop, flush, count, and a FIFO_DEPTH parameter.

Verification
- REQ-041 Reset then zero-wait memory, instr_ready=1: addresses 0x3000, 0x3004, 0x3008 fetched; instr_valid first high in cycle 2 after the first req; op_code = rdata[31:26] (0x3C00_0001 -> 6'h0F).
- REQ-042 instr_ready=0, FIFO_DEPTH=2: exactly two acks accepted, then imem_req=0. Raise ready: fetch resumes at 0x3008.
- REQ-043 Ack delayed 3 cycles and redirect to 0x4000 in the second wait cycle: DROP entered, late data discarded, next request at 0x4000, no stale instr_valid.
- REQ-044 Redirect in the same cycle as an ack and a pop: buffer empty next cycle, pc=redirect_pc, popped entry not re-presented.
- REQ-045 pc=0xFFFF_FFFC fetch: next address 0x0000_0000.
- REQ-046 With IFETCH_PERF_EN, ready held high with a 4-cycle ack delay: stall_cnt increments as specified; rst clears it to 0.
